// File: rtl/meas_div_sched.sv
// meas_div_sched: time-shares one 32-bit restoring divider between the frequency job and the
// two-step duty-cycle chain, delivering registered freq/duty with one-cycle valid strobes.
module meas_div_sched #(
   parameter logic [31:0] CLK_HZ     = 32'd100_000_000,
   parameter logic [31:0] DUTY_SCALE = 32'd100
) (
   input  logic        clk_100M,
   input  logic        rst,
   input  logic        period_valid,
   input  logic [31:0] period_cnt,
   input  logic        window_valid,
   input  logic [31:0] high_cnt,
   input  logic [31:0] total_cnt,
   output logic [27:0] freq,
   output logic [6:0]  duty,
   output logic        freq_valid,
   output logic        duty_valid,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, LOAD, ITER, STORE} state_t;
   typedef enum logic [1:0] {JOB_F, JOB_D1, JOB_D2} job_t;
   state_t      state_q, state_d;
   job_t        job_q, job_d;
   logic [31:0] p_op_q, p_op_d, h_op_q, h_op_d, t_op_q, t_op_d;
   logic [31:0] h_snap_q, h_snap_d, q1_q, q1_d;
   logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
   logic [4:0]  iter_q, iter_d;
   logic        f_pend_q, f_pend_d, d_pend_q, d_pend_d;
   logic [27:0] freq_q, freq_d;
   logic [6:0]  duty_q, duty_d;
   logic        fv_q, fv_d, dv_q, dv_d;
   logic        req_f, req_d, sched, launch_f, launch_d;
   logic [31:0] ld_dvd, ld_dvs;
   logic [32:0] rem_sh, trial;
   assign req_f    = f_pend_q | period_valid;
   assign req_d    = d_pend_q | window_valid;
   // A finishing F or D2 job hands over directly to the next launch; D1 always chains into D2.
   assign sched    = (state_q == IDLE) || (state_q == STORE && job_q != JOB_D1);
   assign launch_f = sched & req_f;
   assign launch_d = sched & ~req_f & req_d;
   assign ld_dvd   = job_q == JOB_F ? CLK_HZ : job_q == JOB_D1 ? t_op_q : h_snap_q;
   assign ld_dvs   = job_q == JOB_F ? p_op_q : job_q == JOB_D1 ? DUTY_SCALE : q1_q;
   // The quotient shifts into the dividend register as its bits are consumed.
   assign rem_sh   = {rem_q, dvd_q[31]};
   assign trial    = rem_sh - {1'b0, dvs_q};
   assign freq       = freq_q;
   assign duty       = duty_q;
   assign freq_valid = fv_q;
   assign duty_valid = dv_q;
   assign busy       = state_q != IDLE;
   always_comb begin
      state_d  = state_q;
      job_d    = job_q;
      p_op_d   = period_valid ? period_cnt : p_op_q;
      h_op_d   = window_valid ? high_cnt : h_op_q;
      t_op_d   = window_valid ? total_cnt : t_op_q;
      f_pend_d = req_f & ~launch_f;
      d_pend_d = req_d & ~launch_d;
      h_snap_d = h_snap_q;
      q1_d     = q1_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      iter_d   = iter_q;
      freq_d   = freq_q;
      duty_d   = duty_q;
      fv_d     = 1'b0;
      dv_d     = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = (launch_f | launch_d) ? LOAD : IDLE;
            job_d   = launch_f ? JOB_F : JOB_D1;
         end
         LOAD: begin
            dvs_d   = ld_dvs;
            dvd_d   = ld_dvs == '0 ? '0 : ld_dvd;
            rem_d   = '0;
            iter_d  = 5'd31;
            h_snap_d = job_q == JOB_D1 ? h_op_q : h_snap_q;
            state_d = ld_dvs == '0 ? STORE : ITER;
         end
         ITER: begin
            rem_d   = trial[32] ? rem_sh[31:0] : trial[31:0];
            dvd_d   = {dvd_q[30:0], ~trial[32]};
            iter_d  = iter_q - 5'd1;
            state_d = iter_q == '0 ? STORE : ITER;
         end
         STORE: begin
            freq_d = job_q == JOB_F ? (|dvd_q[31:28] ? '1 : dvd_q[27:0]) : freq_q;
            fv_d   = job_q == JOB_F;
            duty_d = job_q == JOB_D2 ? (dvd_q > 32'd100 ? 7'd100 : dvd_q[6:0]) : duty_q;
            dv_d   = job_q == JOB_D2;
            if (job_q == JOB_D1) begin
               q1_d    = dvd_q;
               job_d   = JOB_D2;
               state_d = LOAD;
            end else begin
               job_d   = launch_f ? JOB_F : JOB_D1;
               state_d = (launch_f | launch_d) ? LOAD : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_100M) begin
      if (!rst) begin
         state_q  <= IDLE;
         job_q    <= JOB_F;
         p_op_q   <= '0;
         h_op_q   <= '0;
         t_op_q   <= '0;
         f_pend_q <= 1'b0;
         d_pend_q <= 1'b0;
         h_snap_q <= '0;
         q1_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         iter_q   <= '0;
         freq_q   <= '0;
         duty_q   <= '0;
         fv_q     <= 1'b0;
         dv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         job_q    <= job_d;
         p_op_q   <= p_op_d;
         h_op_q   <= h_op_d;
         t_op_q   <= t_op_d;
         f_pend_q <= f_pend_d;
         d_pend_q <= d_pend_d;
         h_snap_q <= h_snap_d;
         q1_q     <= q1_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         iter_q   <= iter_d;
         freq_q   <= freq_d;
         duty_q   <= duty_d;
         fv_q     <= fv_d;
         dv_q     <= dv_d;
      end
   end
endmodule

// File: tb/tb_meas_div_sched.sv
// tb_meas_div_sched: directed and randomized checks of the shared-divider sequencer against an
// arithmetic reference; a second instance with a huge CLK_HZ exercises frequency saturation.
module tb_meas_div_sched;
   localparam logic [31:0] CLK_HZ = 32'd100_000_000;
   localparam logic [31:0] SAT_HZ = 32'hFFFF_FFFF;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        period_valid = 1'b0, window_valid = 1'b0;
   logic [31:0] period_cnt = '0, high_cnt = '0, total_cnt = '0;
   logic [27:0] freq, s_freq;
   logic [6:0]  duty, s_duty;
   logic        freq_valid, duty_valid, busy, s_fv, s_dv, s_busy;
   int errors = 0, checks = 0, cyc = 0, fcnt = 0, dcnt = 0, busy_cnt = 0;
   always #5 clk = ~clk;
   meas_div_sched #(.CLK_HZ(CLK_HZ), .DUTY_SCALE(32'd100)) u_dut (
      .clk_100M(clk), .rst(rst), .period_valid(period_valid), .period_cnt(period_cnt),
      .window_valid(window_valid), .high_cnt(high_cnt), .total_cnt(total_cnt),
      .freq(freq), .duty(duty), .freq_valid(freq_valid), .duty_valid(duty_valid), .busy(busy));
   meas_div_sched #(.CLK_HZ(SAT_HZ), .DUTY_SCALE(32'd100)) u_sat (
      .clk_100M(clk), .rst(rst), .period_valid(period_valid), .period_cnt(period_cnt),
      .window_valid(window_valid), .high_cnt(high_cnt), .total_cnt(total_cnt),
      .freq(s_freq), .duty(s_duty), .freq_valid(s_fv), .duty_valid(s_dv), .busy(s_busy));
   function automatic logic [27:0] f_ref(input longint unsigned hz, input longint unsigned p);
      longint unsigned q;
      if (p == 0) return 28'd0;
      q = hz / p;
      return q > 64'hFFF_FFFF ? 28'hFFF_FFFF : 28'(q);
   endfunction
   function automatic logic [6:0] d_ref(input longint unsigned h, input longint unsigned t);
      longint unsigned d1, q;
      d1 = t / 100;
      if (d1 == 0) return 7'd0;
      q = h / d1;
      return q > 100 ? 7'd100 : 7'(q);
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (busy) busy_cnt++;
      if (freq_valid) fcnt++;
      if (duty_valid) dcnt++;
      if (freq_valid || duty_valid) chk("valid_overlap", 64'(freq_valid & duty_valid), 64'd0);
   endtask
   task automatic pulse(input logic pv, input logic [31:0] p, input logic wv,
                        input logic [31:0] h, input logic [31:0] t);
      period_valid = pv;
      period_cnt   = p;
      window_valid = wv;
      high_cnt     = h;
      total_cnt    = t;
      step();
      period_valid = 1'b0;
      window_valid = 1'b0;
   endtask
   task automatic wait_f(input int s, input int max, input logic [31:0] p, input int lat);
      do step(); while (!freq_valid && (cyc - s) < max);
      chk("freq_latency", freq_valid ? 64'(cyc - s) : 64'hFFFF, 64'(lat));
      chk("freq", 64'(freq), 64'(f_ref(CLK_HZ, p)));
      chk("sat_freq", {35'd0, s_fv, s_freq}, {35'd0, 1'b1, f_ref(SAT_HZ, p)});
   endtask
   task automatic wait_d(input int s, input int max, input logic [31:0] h, input logic [31:0] t,
                         input int lat);
      do step(); while (!duty_valid && (cyc - s) < max);
      chk("duty_latency", duty_valid ? 64'(cyc - s) : 64'hFFFF, 64'(lat));
      chk("duty", 64'(duty), 64'(d_ref(h, t)));
      chk("sat_duty", {55'd0, s_dv, s_duty, s_busy}, {55'd0, 1'b1, d_ref(h, t), busy});
   endtask
   initial begin
      int s, f0, d0, k, lat;
      logic [31:0] p, h, t;
      repeat (3) step();
      chk("rst_freq", 64'(freq), 64'd0);
      chk("rst_duty", 64'(duty), 64'd0);
      chk("rst_valids", {62'd0, freq_valid, duty_valid}, 64'd0);
      chk("rst_busy", {62'd0, busy, s_busy}, 64'd0);
      rst = 1'b1;
      repeat (2) step();
      // single frequency job
      s = cyc; busy_cnt = 0;
      pulse(1'b1, 32'd100_000, 1'b0, 0, 0);
      wait_f(s, 40, 32'd100_000, 35);
      chk("f_value_1000", 64'(freq), 64'd1000);
      chk("f_busy_cycles", 64'(busy_cnt), 64'd34);
      chk("f_busy_end", 64'(busy), 64'd0);
      // duty chain: 25%, 100%, clamp
      s = cyc; busy_cnt = 0;
      pulse(1'b0, 0, 1'b1, 32'd25_000_000, 32'd100_000_000);
      wait_d(s, 80, 32'd25_000_000, 32'd100_000_000, 69);
      chk("d_value_25", 64'(duty), 64'd25);
      chk("d_busy_cycles", 64'(busy_cnt), 64'd68);
      s = cyc;
      pulse(1'b0, 0, 1'b1, 32'd100_000_000, 32'd100_000_000);
      wait_d(s, 80, 32'd100_000_000, 32'd100_000_000, 69);
      s = cyc;
      pulse(1'b0, 0, 1'b1, 32'd300_000_000, 32'd100_000_000);
      wait_d(s, 80, 32'd300_000_000, 32'd100_000_000, 69);
      // zero divisor and large quotient
      s = cyc;
      pulse(1'b1, 32'd0, 1'b0, 0, 0);
      wait_f(s, 10, 32'd0, 3);
      s = cyc;
      pulse(1'b1, 32'd1, 1'b0, 0, 0);
      wait_f(s, 40, 32'd1, 35);
      chk("sat_all_ones", 64'(s_freq), 64'hFFF_FFFF);
      s = cyc;
      pulse(1'b0, 0, 1'b1, 32'd30, 32'd50);
      wait_d(s, 80, 32'd30, 32'd50, 37);
      // simultaneous strobes
      s = cyc; busy_cnt = 0;
      pulse(1'b1, 32'd200_000, 1'b1, 32'd1_000_000, 32'd4_000_000);
      wait_f(s, 40, 32'd200_000, 35);
      wait_d(s, 110, 32'd1_000_000, 32'd4_000_000, 103);
      chk("both_busy_cycles", 64'(busy_cnt), 64'd102);
      // overwrite: only the newest pending F request survives
      s = cyc; f0 = fcnt;
      pulse(1'b1, 32'd4000, 1'b0, 0, 0);
      repeat (4) step();
      pulse(1'b1, 32'd1000, 1'b0, 0, 0);
      repeat (4) step();
      pulse(1'b1, 32'd2000, 1'b0, 0, 0);
      wait_f(s, 40, 32'd4000, 35);
      wait_f(s, 80, 32'd2000, 69);
      chk("f_value_50000", 64'(freq), 64'd50_000);
      repeat (40) step();
      chk("f_job_count", 64'(fcnt - f0), 64'd2);
      // reset during ITER cycle 10 of D1
      pulse(1'b0, 0, 1'b1, 32'd500, 32'd1000);
      repeat (10) step();
      rst = 1'b0;
      f0 = fcnt; d0 = dcnt;
      repeat (2) step();
      chk("mid_rst_outputs", {27'd0, freq, duty, freq_valid, duty_valid, busy}, 64'd0);
      rst = 1'b1;
      repeat (80) step();
      chk("mid_rst_no_valid", 64'((fcnt - f0) + (dcnt - d0)), 64'd0);
      s = cyc;
      pulse(1'b0, 0, 1'b1, 32'd330, 32'd1000);
      wait_d(s, 80, 32'd330, 32'd1000, 69);
      // randomized regression
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: p = $urandom_range(1, 20);
            1: p = $urandom_range(1, 100_000);
            default: p = $urandom;
         endcase
         if (p == 0) p = 1;
         t = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 250) : $urandom;
         h = ($urandom_range(0, 1) == 0) ? $urandom : 32'((64'(t) * 64'($urandom)) >> 32);
         k = $urandom_range(0, 20);
         lat = (t / 100 == 0) ? 71 : 103;
         s = cyc; busy_cnt = 0;
         pulse(1'b1, p, k == 0, h, t);
         if (k > 0) begin
            repeat (k - 1) step();
            pulse(1'b0, 0, 1'b1, h, t);
         end
         wait_f(s, 40, p, 35);
         wait_d(s, 120, h, t, lat);
         chk("rnd_busy_cycles", 64'(busy_cnt), 64'(lat - 1));
         chk("rnd_busy_idle", 64'(busy), 64'd0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
